// File: rtl/afg_pkg.sv
// Shared types and defaults for the arbitrary-function-generator burst sequencer.
package afg_pkg;

    localparam int ADDR_W_DEF       = 12;
    localparam int CNT_W_DEF        = 16;
    localparam int BURST_CONTINUOUS = 0;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT_TRIG,
        S_PLAY,
        S_DONE
    } afg_state_e;

endpackage

// File: rtl/afg_rate_divider.sv
// Sample-rate divider: counts 0..rate_div and asserts tick on the terminal count.
module afg_rate_divider
    import afg_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             clear,
    input  logic [CNT_W-1:0] rate_div,
    output logic             tick
);

    logic [CNT_W-1:0] count;

    assign tick = (count == rate_div);

    always_ff @(posedge Clock) begin
        if (Reset || clear) begin
            count <= '0;
        end else if (tick) begin
            count <= '0;
        end else begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/afg_burst_sequencer.sv
// Plays Start..Stop address bursts on each accepted trigger, Burst_Cnt passes
// (0 = forever), one sample every Rate_Div+1 clocks.
module afg_burst_sequencer
    import afg_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              EN,
    input  logic              Trig_in,
    input  logic [ADDR_W-1:0] Start_Addr,
    input  logic [ADDR_W-1:0] Stop_Addr,
    input  logic [CNT_W-1:0]  Burst_Cnt,
    input  logic [CNT_W-1:0]  Rate_Div,
    output logic [ADDR_W-1:0] Addr,
    output logic              Sample_Valid,
    output logic              Busy,
    output logic              Done,
    output logic              Trig_Miss
);

    afg_state_e        state;
    logic [ADDR_W-1:0] start_sh;
    logic [ADDR_W-1:0] stop_sh;
    logic [CNT_W-1:0]  burst_sh;
    logic [CNT_W-1:0]  rate_sh;
    logic [CNT_W-1:0]  rep_cnt;
    logic              tick;
    logic              continuous;

    assign continuous = (burst_sh == CNT_W'(BURST_CONTINUOUS));

    // Divider is held at zero outside PLAY, so the first sample after a
    // trigger always gets a full Rate_Div+1 period.
    afg_rate_divider #(
        .CNT_W (CNT_W)
    ) u_rate_divider (
        .Clock    (Clock),
        .Reset    (Reset),
        .clear    (state != S_PLAY),
        .rate_div (rate_sh),
        .tick     (tick)
    );

    always_ff @(posedge Clock) begin
        // NOTE: synchronous reset clears every register here, shadows included,
        // so a post-reset burst can never see stale segment bounds.
        if (Reset) begin
            state        <= S_IDLE;
            start_sh     <= '0;
            stop_sh      <= '0;
            burst_sh     <= '0;
            rate_sh      <= '0;
            rep_cnt      <= '0;
            Addr         <= '0;
            Sample_Valid <= 1'b0;
            Busy         <= 1'b0;
            Done         <= 1'b0;
            Trig_Miss    <= 1'b0;
        end else begin
            // NOTE: pulse outputs default low with non-blocking assignment;
            // the later assignment in the same block wins when a pulse is due.
            Done      <= 1'b0;
            Trig_Miss <= 1'b0;

            if (!EN) begin
                state        <= S_IDLE;
                Sample_Valid <= 1'b0;
                Busy         <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        state <= S_WAIT_TRIG;
                    end

                    S_WAIT_TRIG: begin
                        if (Trig_in) begin
                            if (Stop_Addr >= Start_Addr) begin
                                start_sh     <= Start_Addr;
                                stop_sh      <= Stop_Addr;
                                burst_sh     <= Burst_Cnt;
                                rate_sh      <= Rate_Div;
                                rep_cnt      <= Burst_Cnt;
                                Addr         <= Start_Addr;
                                Sample_Valid <= 1'b1;
                                Busy         <= 1'b1;
                                state        <= S_PLAY;
                            end else begin
                                Trig_Miss <= 1'b1;
                            end
                        end
                    end

                    S_PLAY: begin
                        if (Trig_in) begin
                            Trig_Miss <= 1'b1;
                        end
                        if (!tick) begin
                            Sample_Valid <= 1'b0;
                        end else if (Addr < stop_sh) begin
                            Addr         <= Addr + ADDR_W'(1);
                            Sample_Valid <= 1'b1;
                        end else if (continuous) begin
                            Addr         <= start_sh;
                            Sample_Valid <= 1'b1;
                        end else if (rep_cnt == CNT_W'(1)) begin
                            // Last pass finished: Addr keeps the final sample.
                            rep_cnt      <= '0;
                            Sample_Valid <= 1'b0;
                            Busy         <= 1'b0;
                            Done         <= 1'b1;
                            state        <= S_DONE;
                        end else begin
                            rep_cnt      <= rep_cnt - CNT_W'(1);
                            Addr         <= start_sh;
                            Sample_Valid <= 1'b1;
                        end
                    end

                    S_DONE: begin
                        if (Trig_in) begin
                            Trig_Miss <= 1'b1;
                        end
                        state <= S_WAIT_TRIG;
                    end

                    default: begin
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/afg_burst_sequencer.md
Name: afg_burst_sequencer

Overview:
- Sits directly downstream of the infinite-mode trigger/delay circuit.
- Consumes its single-cycle trigger output and plays out a burst of waveform-memory addresses, Start_Addr..Stop_Addr inclusive, repeated Burst_Cnt times.
- Drives the sample-memory read address plus a valid strobe to the DAC output path.
- Reports busy, done and missed-trigger status to the control logic.

Parameters:
ADDR_W, 12, waveform memory address width
CNT_W, 16, width of burst repeat count and rate divider

Ports:
Clock  input  1  system clock, same domain as Clock_Fast of the trigger path
Reset  input  1  synchronous, active-high reset
EN  input  1  sequencer enable; low forces IDLE
Trig_in  input  1  single-cycle trigger pulse from the upstream trigger/delay stage
Start_Addr  input  ADDR_W  first sample address of the waveform segment
Stop_Addr  input  ADDR_W  last sample address, inclusive
Burst_Cnt  input  CNT_W  number of segment passes per trigger; 0 = continuous
Rate_Div  input  CNT_W  sample advances every Rate_Div+1 clocks
Addr  output  ADDR_W  memory read address
Sample_Valid  output  1  high on each cycle a new Addr is issued
Busy  output  1  high while in PLAY
Done  output  1  one-cycle pulse when a finite burst completes
Trig_Miss  output  1  one-cycle pulse when a trigger is ignored or rejected

Behaviour:
- Reset values: Addr=0, Sample_Valid=0, Busy=0, Done=0, Trig_Miss=0. State=IDLE, all internal counters 0.
- States: IDLE, WAIT_TRIG, PLAY, DONE.
- IDLE: go to WAIT_TRIG when EN=1.
- EN=0 in any state: go to IDLE on the next cycle. Any burst in progress is aborted. Sample_Valid and Busy fall on that cycle. Done is not pulsed.
- WAIT_TRIG, Trig_in=1 with Stop_Addr>=Start_Addr:
  - Latch Start_Addr, Stop_Addr, Burst_Cnt and Rate_Div into shadow registers.
  - Set Addr=Start_Addr, load repeat counter = Burst_Cnt, clear divider.
  - Enter PLAY.
  - Sample_Valid=1 on the cycle after the trigger (latency 1).
- WAIT_TRIG, Trig_in=1 with Stop_Addr<Start_Addr: reject. Pulse Trig_Miss, stay in WAIT_TRIG.
- PLAY: the divider counts 0..Rate_Div. When it reaches Rate_Div:
  - divider returns to 0;
  - Addr advances;
  - Sample_Valid pulses for one cycle.
  With Rate_Div=0, Sample_Valid is held high continuously.
- Address advance:
  - Addr<Stop: Addr+1.
  - Addr==Stop: wrap to shadow Start and end one pass.
  - End of pass with Burst_Cnt=0: keep playing indefinitely.
  - End of pass otherwise: decrement the repeat counter. If it becomes 0, enter DONE instead of issuing a new sample.
- DONE: Done=1 for one cycle, Busy=0, return to WAIT_TRIG (or IDLE if EN=0).
- Trig_in during PLAY or DONE is ignored and pulses Trig_Miss. It does not retrigger or extend the burst.
- Live input changes during PLAY have no effect; only the shadow copies are used.
- Single-sample segment (Start==Stop): each pass is one sample.
- Addr holds its last value outside PLAY.
- All arithmetic is unsigned, non-saturating. Address wrap is explicit; there is no modulo-2^ADDR_W roll.
- Reset asserted mid-burst: all outputs return to reset values on the next edge.

Decomposition:
- Shared package afg_pkg holds:
  - the state enum (IDLE, WAIT_TRIG, PLAY, DONE);
  - ADDR_W and CNT_W defaults;
  - a BURST_CONTINUOUS = 0 constant.
- One natural sub-module, afg_rate_divider: a CNT_W counter producing the advance tick from Rate_Div, with sync clear.

Test Plan:
- Start=4, Stop=7, Burst_Cnt=2, Rate_Div=0, one Trig_in pulse:
  - Addr sequence 4,5,6,7,4,5,6,7 on consecutive cycles from trigger+1, Sample_Valid high for 8 cycles;
  - then Done pulses once and Busy falls.
- Rate_Div=2, Start=0, Stop=1, Burst_Cnt=1 -> Sample_Valid pulses every 3rd clock, Addr 0 then 1, Done after the second sample period.
- Burst_Cnt=0, Start=10, Stop=12, run 20 cycles, then EN=0:
  - Addr cycles 10,11,12 repeatedly;
  - Sample_Valid and Busy drop on the cycle after EN falls, with no Done.
- Second Trig_in during PLAY -> Trig_Miss pulses one cycle, address sequence unaffected.
- Start=9, Stop=3, trigger -> Trig_Miss pulses, Busy stays 0, state remains WAIT_TRIG.
- Reset asserted at mid-burst Addr=6 -> next cycle Addr=0 and Sample_Valid=0. After release with EN=1, a new trigger restarts cleanly at Start_Addr.
